// File: rtl/cvxif_result_buffer.sv
// cvxif_result_buffer: in-order elastic buffer from CV-X-IF coprocessor results to the core writeback port.
// Define CVXIF_RESULT_BYPASS_EN for a zero-latency combinational pass-through when the buffer is empty.
module cvxif_result_buffer #(
    parameter int DEPTH    = 4,
    parameter int ID_WIDTH = 3,
    parameter int XLEN     = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       cpr_valid_i,
    output logic                       cpr_ready_o,
    input  logic [ID_WIDTH-1:0]        cpr_id_i,
    input  logic [XLEN-1:0]            cpr_data_i,
    input  logic [4:0]                 cpr_rd_i,
    input  logic                       cpr_we_i,
    input  logic                       cpr_exc_i,
    input  logic [5:0]                 cpr_exccode_i,
    output logic                       core_valid_o,
    input  logic                       core_ready_i,
    output logic [ID_WIDTH-1:0]        core_id_o,
    output logic [XLEN-1:0]            core_data_o,
    output logic [4:0]                 core_rd_o,
    output logic                       core_we_o,
    output logic                       core_exc_o,
    output logic [5:0]                 core_exccode_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]          wr_ptr, rd_ptr;
    logic [ID_WIDTH-1:0]  id_q      [DEPTH];
    logic [XLEN-1:0]      data_q    [DEPTH];
    logic [4:0]           rd_q      [DEPTH];
    logic                 we_q      [DEPTH];
    logic                 exc_q     [DEPTH];
    logic [5:0]           exccode_q [DEPTH];
    logic                 empty, full, push, pop, store, pop_mem, bypass, cpr_we_s;
    logic [AW-1:0]        wr_idx, rd_idx;

    assign wr_idx      = wr_ptr[AW-1:0];
    assign rd_idx      = rd_ptr[AW-1:0];
    assign empty       = wr_ptr == rd_ptr;
    assign full        = (wr_idx == rd_idx) && (wr_ptr[AW] != rd_ptr[AW]);
    assign count_o     = wr_ptr - rd_ptr;
    assign cpr_ready_o = !full && !rst_i;
    assign cpr_we_s    = cpr_we_i && !cpr_exc_i;
    assign push        = cpr_valid_i && cpr_ready_o;
    assign pop         = core_valid_o && core_ready_i;

`ifdef CVXIF_RESULT_BYPASS_EN
    assign bypass = empty && !flush_i && cpr_valid_i;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed result taken by the core the same cycle never occupies an entry.
    assign store   = push && !(bypass && core_ready_i);
    assign pop_mem = pop && !empty;

    always_comb begin
        core_valid_o   = !rst_i && !flush_i && (!empty || bypass);
        core_id_o      = bypass ? cpr_id_i      : id_q[rd_idx];
        core_data_o    = bypass ? cpr_data_i    : data_q[rd_idx];
        core_rd_o      = bypass ? cpr_rd_i      : rd_q[rd_idx];
        core_we_o      = bypass ? cpr_we_s      : we_q[rd_idx];
        core_exc_o     = bypass ? cpr_exc_i     : exc_q[rd_idx];
        core_exccode_o = bypass ? cpr_exccode_i : exccode_q[rd_idx];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (store) wr_ptr <= wr_ptr + 1'b1;
            if (pop_mem) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (store) begin
            id_q[wr_idx]      <= cpr_id_i;
            data_q[wr_idx]    <= cpr_data_i;
            rd_q[wr_idx]      <= cpr_rd_i;
            we_q[wr_idx]      <= cpr_we_s;
            exc_q[wr_idx]     <= cpr_exc_i;
            exccode_q[wr_idx] <= cpr_exccode_i;
        end
    end
endmodule

// File: tb/tb_cvxif_result_buffer.sv
// tb_cvxif_result_buffer: directed plan plus random traffic checked against a queue-based reference.
module tb_cvxif_result_buffer;
    localparam int DEPTH = 4;

    typedef struct {
        logic [2:0]  id;
        logic [63:0] data;
        logic [4:0]  rd;
        logic        we;
        logic        exc;
        logic [5:0]  code;
    } ent_t;

    logic        clk = 0, rst = 1, flush = 0;
    logic        cpr_valid = 0, cpr_ready, cpr_we = 0, cpr_exc = 0;
    logic [2:0]  cpr_id = 0;
    logic [63:0] cpr_data = 0;
    logic [4:0]  cpr_rd = 0;
    logic [5:0]  cpr_code = 0;
    logic        core_valid, core_ready = 0, core_we, core_exc;
    logic [2:0]  core_id;
    logic [63:0] core_data;
    logic [4:0]  core_rd;
    logic [5:0]  core_code;
    logic [2:0]  count;
    int          n_cmp = 0, n_err = 0;
    ent_t        q[$];

    always #5 clk = ~clk;

    cvxif_result_buffer #(.DEPTH(DEPTH), .ID_WIDTH(3), .XLEN(64)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .cpr_valid_i(cpr_valid), .cpr_ready_o(cpr_ready), .cpr_id_i(cpr_id),
        .cpr_data_i(cpr_data), .cpr_rd_i(cpr_rd), .cpr_we_i(cpr_we),
        .cpr_exc_i(cpr_exc), .cpr_exccode_i(cpr_code),
        .core_valid_o(core_valid), .core_ready_i(core_ready), .core_id_o(core_id),
        .core_data_o(core_data), .core_rd_o(core_rd), .core_we_o(core_we),
        .core_exc_o(core_exc), .core_exccode_o(core_code), .count_o(count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] id, input logic [63:0] d,
                         input logic [4:0] rd, input logic we, input logic exc,
                         input logic [5:0] code, input logic rdy);
        cpr_valid = v; cpr_id = id; cpr_data = d; cpr_rd = rd;
        cpr_we = we; cpr_exc = exc; cpr_code = code; core_ready = rdy;
    endtask

    // One clock: check outputs mid-cycle against the reference, then advance it at the edge.
    task automatic cycle();
        ent_t in_e, head;
        logic byp, exp_valid, exp_ready;
        #1;
        in_e = '{cpr_id, cpr_data, cpr_rd, cpr_we && !cpr_exc, cpr_exc, cpr_code};
        byp = 0;
`ifdef CVXIF_RESULT_BYPASS_EN
        byp = q.size() == 0 && !flush && cpr_valid;
`endif
        exp_valid = !rst && !flush && (q.size() > 0 || byp);
        exp_ready = !rst && q.size() < DEPTH;
        head = q.size() > 0 ? q[0] : in_e;
        chk("valid", 64'(core_valid), 64'(exp_valid));
        chk("ready", 64'(cpr_ready), 64'(exp_ready));
        chk("count", 64'(count), 64'(q.size()));
        if (exp_valid) begin
            chk("id", 64'(core_id), 64'(head.id));
            chk("data", core_data, head.data);
            chk("rd", 64'(core_rd), 64'(head.rd));
            chk("we", 64'(core_we), 64'(head.we));
            chk("exc", 64'(core_exc), 64'(head.exc));
            chk("exccode", 64'(core_code), 64'(head.code));
        end
        @(posedge clk);
        if (rst || flush) q.delete();
        else begin
            if (exp_valid && core_ready && q.size() > 0) void'(q.pop_front());
            if (cpr_valid && exp_ready && !(byp && core_ready)) q.push_back(in_e);
        end
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1; cycle(); cycle();
        rst = 0;
        // single result
        drive(1, 3'd2, 64'hDEAD_BEEF, 5'd7, 1, 0, 0, 1); cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 1); cycle(); cycle();
        // fill while stalled, 5th refused, then drain in order
        for (int i = 0; i < 5; i++) begin
            drive(1, 3'(i), 64'(i * 17), 5'(i), 1, 0, 0, 0); cycle();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) cycle();
        // continuous push+pop with ids cycling, wrapping the pointers
        drive(1, 3'd0, 64'h100, 5'd1, 1, 0, 0, 0); cycle();
        for (int i = 1; i <= 10; i++) begin
            drive(1, 3'(i), 64'h100 + 64'(i), 5'(i), 1, 0, 0, 1); cycle();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1); cycle(); cycle();
        // exception sanitise
        drive(1, 3'd5, 64'h55, 5'd3, 1, 1, 6'h02, 0); cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 1); cycle(); cycle();
        // flush with push in the same cycle
        for (int i = 0; i < 3; i++) begin
            drive(1, 3'(i), 64'(i), 5'(i), 1, 0, 0, 0); cycle();
        end
        drive(1, 3'd6, 64'hF1, 5'd9, 1, 0, 0, 1); flush = 1; cycle();
        flush = 0; drive(0, 0, 0, 0, 0, 0, 0, 1); cycle(); cycle();
        // reset mid-stream
        for (int i = 0; i < 2; i++) begin
            drive(1, 3'(i), 64'(i + 40), 5'(i), 1, 0, 0, 0); cycle();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0); rst = 1; cycle();
        rst = 0; cycle();
        // random traffic
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 2) != 0), 3'($urandom), {$urandom, $urandom},
                  5'($urandom), 1'($urandom), 1'($urandom_range(0, 5) == 0),
                  6'($urandom), 1'($urandom_range(0, 2) != 0));
            flush = $urandom_range(0, 40) == 0;
            rst = $urandom_range(0, 80) == 0;
            cycle();
        end
        flush = 0; rst = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/cvxif_result_buffer.md
# cvxif_result_buffer

Elastic result buffer between the CV-X-IF coprocessor's result port and the core's result/writeback port. It absorbs coprocessor results when the core cannot take them and presents them in arrival order with a valid/ready handshake. Exceptions are sanitised: an excepting result never requests a register write. It sits directly downstream of the coprocessor and upstream of the core's CV-X-IF result consumer.

## Interface
Reset is synchronous and active-high; single clock domain.

Parameters:
- DEPTH, 4, number of entries; power of two, ≥2
- ID_WIDTH, 3, offload instruction id width
- XLEN, 64, result data width

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  synchronous active-high reset
- flush_i  in  1  drop all buffered entries (pipeline flush)
- cpr_valid_i  in  1  coprocessor result valid
- cpr_ready_o  out  1  buffer can accept a result
- cpr_id_i  in  ID_WIDTH  instruction id
- cpr_data_i  in  XLEN  result value
- cpr_rd_i  in  5  destination register
- cpr_we_i  in  1  register write request
- cpr_exc_i  in  1  result carries an exception
- cpr_exccode_i  in  6  exception code
- core_valid_o  out  1  result presented to core
- core_ready_i  in  1  core accepts result
- core_id_o, core_data_o, core_rd_o, core_we_o, core_exc_o, core_exccode_o  out  same widths as cpr_*  head-entry fields
- count_o  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Circular storage; wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits (extra wrap bit). Empty when the pointers are equal. Full when the index bits are equal and the wrap bits differ. count_o = wr_ptr − rd_ptr, modulo 2^($clog2(DEPTH)+1).
- Push: cpr_valid_i && cpr_ready_o. Pop: core_valid_o && core_ready_i.
- cpr_ready_o = !full && !rst_i. It depends only on registered state, never on core_ready_i.
- core_valid_o = !empty && !flush_i. The head fields are driven from storage at rd_ptr.
- Stored we = cpr_we_i && !cpr_exc_i. All other fields are stored unchanged.
- A push and a pop in the same cycle are legal: both pointers advance and count is unchanged. When full, cpr_ready_o=0, so no push can occur. Pop still proceeds.
- Pointers advance mod 2^($clog2(DEPTH)+1); the index wraps naturally from DEPTH−1 to 0.
- flush_i has priority over everything. The next edge sets rd_ptr := wr_ptr := 0. A push handshaken in the flush cycle is discarded. core_valid_o is 0 in the flush cycle, so no pop occurs.
- rst_i mid-operation behaves like flush: all entries are lost and the pointers are zeroed on the edge.
- Storage contents are not reset; only the pointers are.

## Timing
- Reset values, while rst_i=1 and after the reset edge:
  - core_valid_o=0, count_o=0, pointers=0.
  - cpr_ready_o=0 while rst_i is high, 1 in the first cycle after reset.
  - Data outputs are don't-care while core_valid_o=0.
- Default latency: a result pushed at edge N is visible on core_valid_o in cycle N+1 (one cycle).
- Throughput: one push and one pop per cycle sustained.
- core_*_o fields are stable while core_valid_o=1 && core_ready_i=0.
- count_o updates on the edge after a push or pop.

## Configuration
- Macro CVXIF_RESULT_BYPASS_EN.
- Defined: when the buffer is empty and flush_i=0, then:
  - core_valid_o = cpr_valid_i, combinationally.
  - core_*_o pass cpr_*_i through, with the we sanitisation applied.
  - If core_ready_i=1 in that cycle, the result is consumed and not stored (pointers unchanged).
  - If core_ready_i=0, the result is stored normally.
  - Latency is 0 cycles from an empty buffer.
- Not defined: no combinational path from cpr_* to core_*. Latency is always 1 cycle and all outputs are driven from registers or storage.

## Test plan
- Reset then single result: push id=2, data=0xDEAD_BEEF, rd=7, we=1 with core_ready_i=1.
  - Without macro: core_valid_o=1 one cycle later with identical fields, count_o returns to 0.
  - With macro: the same fields appear in the same cycle and count_o stays 0.
- Fill with core stalled: core_ready_i=0, push ids 0..3 (DEPTH=4) → count_o=4 and cpr_ready_o=0. A 5th valid is not accepted. Release core_ready_i → ids 0,1,2,3 pop in order on consecutive cycles.
- Wrap-around: push and pop at the same time continuously for 10 results with ids 0..7 cycling → output order matches input order, count_o stays at 1, and the pointer wrap bit toggles correctly.
- Exception sanitise: push exc=1, exccode=0x02, we=1 → core_exc_o=1, core_exccode_o=0x02, core_we_o=0.
- Flush: hold 3 entries, assert flush_i for one cycle while a push is handshaken.
  - core_valid_o=0 during the flush cycle.
  - Next cycle: count_o=0, core_valid_o=0, and the flushed push never appears.
- Reset mid-stream: rst_i asserted with 2 entries held → core_valid_o=0 and cpr_ready_o=0 during reset; count_o=0 after reset.
